// File: rtl/fdivsu_seq.sv
`default_nettype none
// ============================================================================
// Module      : fdivsu_seq
// Description : Bit-serial restoring fractional divider; inverse of FMULSU.
// Revision    : 1.0 - initial release
// ============================================================================

module fdivsu_seq #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_r1,
  input  logic [W-1:0] i_r0,
  input  logic [W-1:0] i_rr,
  input  logic         i_ack,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_quot,
  output logic [W-1:0] o_rem,
  output logic         o_ovf,
  output logic         o_dz
);

  localparam int DW = 2 * W - 1;
  localparam int CW = $clog2(DW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);
  localparam logic [W-1:0]  QMAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  QMIN     = {1'b1, {(W-1){1'b0}}};
  localparam logic [DW-1:0] POS_LIM  = DW'((1 << (W - 1)) - 1);
  localparam logic [DW-1:0] NEG_LIM  = DW'(1 << (W - 1));

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dmag_q, dmag_d;
  logic [DW-1:0] qmag_q, qmag_d;
  logic [W-1:0]  prem_q, prem_d;
  logic [W-1:0]  rr_q, rr_d;
  logic          neg_q, neg_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;
  logic          valid_q, valid_d;

  // The product pair carries one extra LSB; the arithmetic shift drops it.
  logic [2*W-1:0] w_dsh;
  logic [2*W-1:0] w_dabs;
  logic [W:0]     w_trial;
  logic           w_ge;

  assign w_dsh   = {i_r1[W-1], i_r1, i_r0[W-1:1]};
  assign w_dabs  = i_r1[W-1] ? (~w_dsh + 1'b1) : w_dsh;
  assign w_trial = {prem_q, dmag_q[DW-1]};
  assign w_ge    = (w_trial >= {1'b0, rr_q});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dmag_q  <= '0;
      qmag_q  <= '0;
      prem_q  <= '0;
      rr_q    <= '0;
      neg_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dmag_q  <= dmag_d;
      qmag_q  <= qmag_d;
      prem_q  <= prem_d;
      rr_q    <= rr_d;
      neg_q   <= neg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dmag_d  = dmag_q;
    qmag_d  = qmag_q;
    prem_d  = prem_q;
    rr_d    = rr_q;
    neg_d   = neg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CALC;
          cnt_d   = CNT_INIT;
          dmag_d  = w_dabs[DW-1:0];
          neg_d   = i_r1[W-1];
          rr_d    = i_rr;
          qmag_d  = '0;
          prem_d  = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end

      S_CALC: begin
        // Remainder stays below rr, so the W-bit difference is exact.
        prem_d = w_ge ? (w_trial[W-1:0] - rr_q) : w_trial[W-1:0];
        qmag_d = {qmag_q[DW-2:0], w_ge};
        dmag_d = {dmag_q[DW-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_DONE;
        rem_d   = neg_q ? (-prem_q) : prem_q;
        if (rr_q == '0) begin
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
          rem_d  = '0;
          quot_d = neg_q ? QMIN : QMAX;
        end else if (!neg_q && (qmag_q > POS_LIM)) begin
          ovf_d  = 1'b1;
          quot_d = QMAX;
        end else if (neg_q && (qmag_q > NEG_LIM)) begin
          ovf_d  = 1'b1;
          quot_d = QMIN;
        end else begin
          ovf_d  = 1'b0;
          quot_d = neg_q ? (-qmag_q[W-1:0]) : qmag_q[W-1:0];
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        if (valid_q && i_ack) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_valid = valid_q;
    o_quot  = quot_q;
    o_rem   = rem_q;
    o_ovf   = ovf_q;
    o_dz    = dz_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fdivsu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for fdivsu_seq: directed table, FMULSU-model random, handshake and reset sequences.

module tb_fdivsu_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] r1    = '0;
  logic [7:0] r0    = '0;
  logic [7:0] rr    = '0;
  logic       ready, valid, ovf, dz;
  logic [7:0] quot, rem;

  int n_cmp  = 0;
  int n_fail = 0;

  fdivsu_seq #(.W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_r1    (r1),
    .i_r0    (r0),
    .i_rr    (rr),
    .i_ack   (ack),
    .o_ready (ready),
    .o_valid (valid),
    .o_quot  (quot),
    .o_rem   (rem),
    .o_ovf   (ovf),
    .o_dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r1, r0, rr, q, rm;
    logic       ovf, dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one start and wait for o_valid; returns edges counted after the start edge.
  task automatic do_op(input logic [7:0] a1, input logic [7:0] a0, input logic [7:0] b,
                       output int lat);
    @(negedge clk);
    r1 = a1; r0 = a0; rr = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r1 = 8'($urandom); r0 = 8'($urandom); rr = 8'($urandom);
    chk("ready_low_after_start", 32'(ready), 32'd0);
    chk("flags_cleared_on_start", {30'd0, ovf, dz}, 32'd0);
    lat = 0;
    while (!valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("ack_ready", 32'(ready), 32'd1);
    chk("ack_valid", 32'(valid), 32'd0);
  endtask

  vec_t vt[11];
  int   lat;

  initial begin
    vt[0]  = '{8'h40, 8'h00, 8'h80, 8'h40, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{8'hFF, 8'hE2, 8'h05, 8'hFD, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{8'hFF, 8'hEA, 8'h04, 8'hFE, 8'hFD, 1'b0, 1'b0};
    vt[3]  = '{8'h00, 8'h16, 8'h04, 8'h02, 8'h03, 1'b0, 1'b0};
    vt[4]  = '{8'h7F, 8'hFE, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0};
    vt[5]  = '{8'h80, 8'h00, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    vt[7]  = '{8'h12, 8'h34, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1};
    vt[8]  = '{8'h92, 8'h34, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{8'hFE, 8'h00, 8'h03, 8'hAB, 8'hFF, 1'b0, 1'b0};
    vt[10] = '{8'h01, 8'h90, 8'hFA, 8'h00, 8'hC8, 1'b0, 1'b0};

    // Reset state.
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_quot_rem", {16'd0, quot, rem}, 32'd0);
    chk("rst_flags", {30'd0, ovf, dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op(vt[i].r1, vt[i].r0, vt[i].rr, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
      chk($sformatf("vec%0d_quot", i), 32'(quot), 32'(vt[i].q));
      chk($sformatf("vec%0d_rem", i), 32'(rem), 32'(vt[i].rm));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
      chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(vt[i].dz));
      do_ack();
    end

    // FMULSU reference model: product = rd*rr, pair = product << 1; |rd*rr| kept within 2^14.
    for (int k = 0; k < 1500; k++) begin
      logic [7:0]  rd, dv;
      logic [15:0] p, pp;
      rd = 8'($urandom_range(0, 255));
      dv = 8'($urandom_range(1, 128));
      p  = 16'($signed({{8{rd[7]}}, rd}) * $signed({8'd0, dv}));
      pp = p << 1;
      do_op(pp[15:8], pp[7:0], dv, lat);
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'd17);
      chk($sformatf("rnd%0d_quot rd=%0h rr=%0h", k, rd, dv), 32'(quot), 32'(rd));
      chk($sformatf("rnd%0d_rem", k), 32'(rem), 32'd0);
      chk($sformatf("rnd%0d_flags", k), {30'd0, ovf, dz}, 32'd0);
      do_ack();
    end

    // Handshake: start pulsed mid-CALC and in DONE is ignored; ack held off keeps outputs stable.
    @(negedge clk);
    r1 = 8'h00; r0 = 8'h16; rr = 8'h04; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin
      @(negedge clk);
      start = (lat == 5);
      r1 = 8'h92; r0 = 8'h00; rr = 8'h00;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("hs_latency", 32'(lat), 32'd17);
    chk("hs_quot", 32'(quot), 32'h02);
    chk("hs_rem", 32'(rem), 32'h03);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      @(posedge clk);
      #1;
      chk($sformatf("hs_hold%0d", i), {15'd0, valid, ready, 7'd0, quot, rem},
          {15'd0, 1'b1, 1'b0, 7'd0, 8'h02, 8'h03});
    end
    @(negedge clk);
    start = 1'b0;
    ack = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0; start = 1'b0;
    chk("hs_ackstart_ready", 32'(ready), 32'd1);
    chk("hs_ackstart_valid", 32'(valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hs_no_new_op", 32'(ready), 32'd1);
    chk("hs_idle_hold", {16'd0, quot, rem}, 32'h0203);

    // Asynchronous reset mid-CALC clears everything without a clock edge.
    @(negedge clk);
    r1 = 8'h40; r0 = 8'h00; rr = 8'h80; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_outputs", {14'd0, ovf, dz, quot, rem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h40, 8'h00, 8'h80, lat);
    chk("post_rst_latency", 32'(lat), 32'd17);
    chk("post_rst_quot", 32'(quot), 32'h40);
    chk("post_rst_rem", 32'(rem), 32'h00);
    chk("post_rst_flags", {30'd0, ovf, dz}, 32'd0);
    do_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
